rv32_grng_unit: RTL

Execute-stage responder for the custom GRNG extension: it acts on the `grng_ctrl.set_seed` and `grng_ctrl.enable` controls that decode produces. A xorshift32 generator runs in the background. The unit turns its output into approximately Gaussian samples by summing bytes (central-limit approximation) and buffers the samples in a small FIFO. When the buffer is empty, the unit stalls the pipeline. The returned sample is written to rd through the `WB_GRNG` writeback path.

---
 rtl/rv32_grng_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rv32_grng_unit.sv
// rv32_grng_unit: execute-stage GRNG responder.
// A xorshift32 generator runs in the background. Each group of NUM_WORDS
// byte-sums is turned into one centred, approximately Gaussian sample, and
// the samples are buffered in a small FIFO that the pipeline pops on enable.
module rv32_grng_unit #(
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_seed_i,
    input  logic [31:0] seed_i,
    input  logic        enable_i,
    input  logic        pipe_stall_i,
    output logic [31:0] sample_o,
    output logic        grng_busy_o
);

    localparam int unsigned ACC_W = $clog2(NUM_WORDS * 1020 + 1);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [ACC_W:0]     OFFSET   = (ACC_W + 1)'(NUM_WORDS * 510);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [OCC_W-1:0]   OCC_FULL = OCC_W'(DEPTH);

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [9:0] byte_sum(input logic [31:0] w);
        return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
    endfunction

    logic [31:0]       state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occ;

    logic              fifo_empty;
    logic              fifo_full;
    logic              seed_load;
    logic              pop;
    logic              active;
    logic              last_word;
    logic              push;
    logic [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W:0] sample_diff;
    logic [31:0]       sample_ext;

    assign fifo_empty  = (occ == '0);
    assign fifo_full   = (occ == OCC_FULL);
    assign seed_load   = set_seed_i && !pipe_stall_i;
    assign pop         = enable_i && !fifo_empty && !pipe_stall_i && !set_seed_i;
    // A pop frees a slot this very edge, so a full FIFO still advances then.
    assign active      = !fifo_full || pop;
    assign last_word   = (cnt == CNT_LAST);
    assign push        = active && last_word && !seed_load;

    assign acc_sum     = acc + ACC_W'(byte_sum(state));
    assign sample_diff = $signed({1'b0, acc_sum}) - $signed(OFFSET);
    assign sample_ext  = {{(31 - ACC_W){sample_diff[ACC_W]}}, sample_diff};

    assign sample_o    = mem[rd_ptr];
    assign grng_busy_o = enable_i && fifo_empty && !set_seed_i;

    // Generator: xorshift state, byte-sum accumulator and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_SEED;
            acc   <= '0;
            cnt   <= '0;
        end else if (seed_load) begin
            state <= (seed_i == '0) ? 32'h0000_0001 : seed_i;
            acc   <= '0;
            cnt   <= '0;
        end else if (active) begin
            state <= xs_step(state);
            if (last_word) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sample FIFO: circular buffer with explicit occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (seed_load) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample_ext;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule
